// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps fetch/decode/execute/memory/writeback for
// R-type, addi, sw and lw over req/ready memories, guarded by a wait watchdog.
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic [4:0]       opcode,
    input  logic [4:0]       alu_field,
    input  logic             mem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             aluinb,
    output logic [4:0]       alu_op,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             rdst,
    output logic             rwd,
    output logic             busy,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state, state_n;
    logic [4:0]        op_q, aluf_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              halt_pend;
    logic              waiting, timeout_hit, stop, retire, set_err;
    logic [1:0]        err_n;
    logic              imm_sel;
    logic [4:0]        exec_op;

    assign waiting     = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timeout_hit = (TIMEOUT > 0) && waiting && (wait_cnt == WAIT_LAST);
    // A halt pulse seen anywhere inside an instruction is remembered until its boundary.
    assign stop        = halt_req || halt_pend;
    assign imm_sel     = (op_q != OP_R);
    assign exec_op     = (op_q == OP_R) ? aluf_q : 5'd0;
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        aluinb   = 1'b0;
        alu_op   = 5'd0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        rdst     = 1'b0;
        rwd      = 1'b0;
        retire   = 1'b0;
        set_err  = 1'b0;
        err_n    = 2'b00;
        case (state)
            S_IDLE: begin
                if (start && !halt_req) state_n = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_n = S_DECODE;
                end else if (timeout_hit) begin
                    state_n = S_ERROR;
                    set_err = 1'b1;
                    err_n   = 2'b10;
                end
            end
            S_DECODE: begin
                if (opcode == OP_R || opcode == OP_ADDI || opcode == OP_SW || opcode == OP_LW) begin
                    state_n = S_EXEC;
                end else begin
                    state_n = S_ERROR;
                    set_err = 1'b1;
                    err_n   = 2'b01;
                end
            end
            S_EXEC: begin
                aluinb  = imm_sel;
                alu_op  = exec_op;
                state_n = (op_q == OP_SW || op_q == OP_LW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                aluinb   = imm_sel;
                alu_op   = exec_op;
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_SW) begin
                        retire  = 1'b1;
                        state_n = stop ? S_IDLE : S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_n = S_ERROR;
                    set_err = 1'b1;
                    err_n   = 2'b10;
                end
            end
            S_WB: begin
                aluinb  = imm_sel;
                alu_op  = exec_op;
                rf_we   = 1'b1;
                rdst    = (op_q == OP_R);
                rwd     = (op_q == OP_LW);
                retire  = 1'b1;
                state_n = stop ? S_IDLE : S_FETCH;
            end
            S_ERROR: begin
                state_n = S_ERROR;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= 5'd0;
            aluf_q    <= 5'd0;
            wait_cnt  <= '0;
            halt_pend <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'b00;
            retired   <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) begin
                op_q   <= opcode;
                aluf_q <= alu_field;
            end
            if (waiting && (state_n == state)) wait_cnt <= wait_cnt + 1'b1;
            else                               wait_cnt <= '0;
            if (retire)                                          halt_pend <= 1'b0;
            else if (halt_req && busy && (state != S_ERROR))     halt_pend <= 1'b1;
            if (set_err) begin
                error    <= 1'b1;
                err_code <= err_n;
            end
            if (retire) retired <= retired + 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle control vector and retired count.
module tb_multicycle_sequencer;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    localparam logic [17:0] IMEM = 18'd1 << 17;
    localparam logic [17:0] IRW  = 18'd1 << 16;
    localparam logic [17:0] PCW  = 18'd1 << 15;
    localparam logic [17:0] AINB = 18'd1 << 14;
    localparam logic [17:0] DREQ = 18'd1 << 8;
    localparam logic [17:0] DWE  = 18'd1 << 7;
    localparam logic [17:0] RFWE = 18'd1 << 6;
    localparam logic [17:0] RDST = 18'd1 << 5;
    localparam logic [17:0] RWD  = 18'd1 << 4;
    localparam logic [17:0] BUSY = 18'd1 << 3;
    localparam logic [17:0] ERR  = 18'd1 << 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             halt_req = 1'b0;
    logic [4:0]       opcode = 5'd0;
    logic [4:0]       alu_field = 5'd0;
    logic             mem_ready = 1'b0;
    logic             imem_req, ir_we, pc_we, aluinb, dmem_req, dmem_we;
    logic             rf_we, rdst, rwd, busy, error;
    logic [4:0]       alu_op;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] retired;
    logic [17:0]      obs;

    int checks  = 0;
    int errors  = 0;
    int exp_ret = 0;

    multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
        .opcode(opcode), .alu_field(alu_field), .mem_ready(mem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .aluinb(aluinb),
        .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
        .rdst(rdst), .rwd(rwd), .busy(busy), .error(error), .err_code(err_code),
        .retired(retired)
    );

    always #5 clock = ~clock;

    assign obs = {imem_req, ir_we, pc_we, aluinb, alu_op, dmem_req, dmem_we,
                  rf_we, rdst, rwd, busy, error, err_code};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [4:0] op);
        return (op == 5'd0) || (op == 5'd5) || (op == 5'd7) || (op == 5'd8);
    endfunction

    // ALU-side controls once the instruction is executing.
    function automatic logic [17:0] dp(input logic [4:0] op, input logic [4:0] aluf);
        logic [4:0] aop;
        aop = (op == 5'd0) ? aluf : 5'd0;
        return ((op != 5'd0) ? AINB : 18'd0) | {4'd0, aop, 9'd0};
    endfunction

    task automatic step(input string tag, input logic [17:0] exp, input bit inc);
        @(negedge clock);
        chk({tag, ".out"}, 32'(obs), 32'(exp));
        chk({tag, ".ret"}, 32'(retired), 32'(exp_ret));
        @(posedge clock);
        #1;
        if (inc) exp_ret = (exp_ret + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        #2;
        chk("rst.out", 32'(obs), 32'd0);
        chk("rst.ret", 32'(retired), 32'd0);
        exp_ret = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic launch();
        start = 1'b1; halt_req = 1'b0; mem_ready = 1'(($urandom));
        step("idle_start", 18'd0, 1'b0);
    endtask

    // Expects the DUT in FETCH; leaves it in FETCH, IDLE (halt) or ERROR (illegal).
    task automatic run_instr(input logic [4:0] op, input logic [4:0] aluf,
                             input int fw, input int mw, input bit halt);
        logic [17:0] d;
        d = dp(op, aluf);
        halt_req = 1'b0;
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0; start = 1'(($urandom));
            step("fetch_wait", IMEM | BUSY, 1'b0);
        end
        mem_ready = 1'b1; start = 1'(($urandom));
        step("fetch", IMEM | IRW | PCW | BUSY, 1'b0);
        opcode = op; alu_field = aluf; mem_ready = 1'(($urandom));
        step("decode", BUSY, 1'b0);
        opcode = 5'(($urandom)); alu_field = 5'(($urandom));
        if (!legal(op)) return;
        halt_req = halt; mem_ready = 1'(($urandom));
        step("exec", d | BUSY, 1'b0);
        halt_req = 1'b0;
        if (op == 5'd7 || op == 5'd8) begin
            for (int i = 0; i < mw; i++) begin
                mem_ready = 1'b0;
                step("mem_wait", d | DREQ | ((op == 5'd7) ? DWE : 18'd0) | BUSY, 1'b0);
            end
            mem_ready = 1'b1;
            step("mem", d | DREQ | ((op == 5'd7) ? DWE : 18'd0) | BUSY, op == 5'd7);
        end
        if (op != 5'd7) begin
            mem_ready = 1'(($urandom));
            step("wb", d | RFWE | ((op == 5'd0) ? RDST : 18'd0) | ((op == 5'd8) ? RWD : 18'd0) | BUSY, 1'b1);
        end
    endtask

    task automatic error_hold(input logic [1:0] ec);
        for (int k = 0; k < 3; k++) begin
            start = 1'(($urandom)); halt_req = 1'(($urandom)); mem_ready = 1'(($urandom));
            step("error", BUSY | ERR | {16'd0, ec}, 1'b0);
        end
    endtask

    task automatic do_instr(input logic [4:0] op, input logic [4:0] aluf,
                            input int fw, input int mw, input bit halt);
        run_instr(op, aluf, fw, mw, halt);
        if (!legal(op)) begin
            error_hold(2'b01);
            do_reset();
            launch();
        end else if (halt) begin
            start = 1'b0; mem_ready = 1'(($urandom));
            step("halted", 18'd0, 1'b0);
            launch();
        end
    endtask

    task automatic timeout_case(input bit in_mem);
        if (in_mem) begin
            mem_ready = 1'b1;
            step("fetch", IMEM | IRW | PCW | BUSY, 1'b0);
            opcode = 5'd8; alu_field = 5'(($urandom));
            step("decode", BUSY, 1'b0);
            step("exec", AINB | BUSY, 1'b0);
            for (int i = 0; i < TIMEOUT; i++) begin
                mem_ready = 1'b0;
                step("to_mem_wait", AINB | DREQ | BUSY, 1'b0);
            end
        end else begin
            for (int i = 0; i < TIMEOUT; i++) begin
                mem_ready = 1'b0;
                step("to_fetch_wait", IMEM | BUSY, 1'b0);
            end
        end
        error_hold(2'b10);
    endtask

    initial begin
        logic [4:0] op;
        int r, fw, mw;
        do_reset();
        start = 1'b1; halt_req = 1'b1;
        step("idle_halt", 18'd0, 1'b0);
        start = 1'b0; halt_req = 1'b0;
        step("idle", 18'd0, 1'b0);
        launch();

        do_instr(5'd5, 5'd9, 0, 0, 1'b0);
        do_instr(5'd0, 5'd3, 0, 0, 1'b0);
        do_instr(5'd8, 5'd1, 0, 3, 1'b0);
        do_instr(5'd7, 5'd2, 0, 0, 1'b0);
        do_instr(5'd0, 5'd17, TIMEOUT - 1, 0, 1'b0);
        do_instr(5'd8, 5'd4, 0, TIMEOUT - 1, 1'b0);
        do_instr(5'd5, 5'd6, 0, 0, 1'b1);
        do_instr(5'd7, 5'd6, 1, 2, 1'b1);
        do_instr(5'd31, 5'd0, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 9: op = 5'd0;
                2, 3:    op = 5'd5;
                4, 5:    op = 5'd7;
                6, 7:    op = 5'd8;
                default: begin
                    op = 5'(($urandom));
                    while (legal(op)) op = 5'(($urandom));
                end
            endcase
            fw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 2));
            do_instr(op, 5'(($urandom)), fw, mw, $urandom_range(0, 4) == 0);
        end

        timeout_case(1'b0);
        do_reset();
        launch();
        timeout_case(1'b1);
        do_reset();
        launch();

        do_instr(5'd5, 5'd0, 0, 0, 1'b0);
        mem_ready = 1'b1;
        step("fetch", IMEM | IRW | PCW | BUSY, 1'b0);
        opcode = 5'd7;
        step("decode", BUSY, 1'b0);
        step("exec", AINB | BUSY, 1'b0);
        mem_ready = 1'b0;
        @(negedge clock);
        chk("sw_mem.dmem_we", 32'(dmem_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid.dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.ret", 32'(retired), 32'd0);
        exp_ret = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        launch();
        do_instr(5'd0, 5'd12, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
